demux_1to2_stream: RTL and testbench

DEMUX_1TO2_STREAM -- requirements
Module: demux_1to2_stream

---
 rtl/demux_1to2_stream_pkg.sv | 12 +
 rtl/demux_slot.sv | 58 +++++
 rtl/demux_1to2_stream.sv | 69 ++++++
 tb/tb_demux_1to2_stream.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to2_stream_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package demux_1to2_stream_pkg;

  localparam int DEFAULT_N  = 32;
  localparam int DEFAULT_CW = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot with a saturating delivered-word counter.
module demux_slot
  import demux_1to2_stream_pkg::*;
#(
  parameter int n  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [n-1:0]  load_data,
  output logic          valid,
  input  logic          ready,
  output logic [n-1:0]  data,
  output logic [CW-1:0] cnt,
  output slot_state_e   state
);

  slot_state_e state_next;
  logic        drain;

  assign valid = (state == SLOT_FULL);
  assign drain = valid && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A load in the same cycle as a drain keeps the slot FULL with the new word.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (load) state_next = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  // Payload needs no reset: it is only observed while valid is high.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (drain && (cnt != {CW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// Routes one valid/ready input stream to one of two buffered outputs by in_sel.
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int n  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_data,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [n-1:0]  out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [n-1:0]  out1_data,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid never drops until taken.
  slot_state_e state0;
  slot_state_e state1;
  logic        accept;
  logic        load0;
  logic        load1;

  always_comb begin
    in_ready = 1'b0;
    if (in_sel) begin
      in_ready = (state1 == SLOT_EMPTY) || out1_ready;
    end else begin
      in_ready = (state0 == SLOT_EMPTY) || out0_ready;
    end
  end

  assign accept = in_valid && in_ready;
  assign load0  = accept && !in_sel;
  assign load1  = accept && in_sel;

  demux_slot #(.n(n), .CW(CW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data),
    .valid     (out0_valid),
    .ready     (out0_ready),
    .data      (out0_data),
    .cnt       (cnt0),
    .state     (state0)
  );

  demux_slot #(.n(n), .CW(CW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .valid     (out1_valid),
    .ready     (out1_ready),
    .data      (out1_data),
    .cnt       (cnt1),
    .state     (state1)
  );

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed bench for demux_1to2_stream: default-width DUT plus a CW=4 DUT.
module tb_demux_1to2_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic [15:0] cnt0, cnt1;

  logic        s_rst_n;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_data;
  logic        s_in_sel;
  logic        s_out0_valid, s_out1_valid;
  logic        s_out0_ready, s_out1_ready;
  logic [31:0] s_out0_data, s_out1_data;
  logic [3:0]  s_cnt0, s_cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_1to2_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  demux_1to2_stream #(.n(32), .CW(4)) s_dut (
    .clk(clk), .rst_n(s_rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_sel(s_in_sel),
    .out0_valid(s_out0_valid), .out0_ready(s_out0_ready), .out0_data(s_out0_data),
    .out1_valid(s_out1_valid), .out1_ready(s_out1_ready), .out1_data(s_out1_data),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1234_5678;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    tests++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      fails++; $display("FAIL reset_valid got=%b exp=00", {out0_valid, out1_valid});
    end
    tests++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      fails++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
    end
  endtask

  task automatic test_routing();
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_0001;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL route_ready0 got=%b exp=1", in_ready);
    end
    tick();
    in_sel = 1'b1; in_data = 32'hBBBB_0002;
    tests++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hAAAA_0001 || out1_valid !== 1'b0) begin
      fails++; $display("FAIL route_out0 got=%b/%h/%b exp=1/aaaa0001/0", out0_valid, out0_data, out1_valid);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hBBBB_0002 || out0_valid !== 1'b0) begin
      fails++; $display("FAIL route_out1 got=%b/%h/%b exp=1/bbbb0002/0", out1_valid, out1_data, out0_valid);
    end
    tick();
    tests++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd1 || out1_valid !== 1'b0) begin
      fails++; $display("FAIL route_cnt got=%0d/%0d/%b exp=1/1/0", cnt0, cnt1, out1_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1111_0001;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_first_ready got=%b exp=1", in_ready);
    end
    tick();
    in_data = 32'h2222_0002;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_second_ready got=%b exp=0", in_ready);
    end
    tick(); tick();
    tests++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h1111_0001) begin
      fails++; $display("FAIL bp_hold got=%b/%h exp=1/11110001", out0_valid, out0_data);
    end
    in_sel = 1'b1; in_data = 32'h3333_0003;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_parallel_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h3333_0003 || out0_data !== 32'h1111_0001) begin
      fails++; $display("FAIL bp_parallel got=%b/%h/%h exp=1/33330003/11110001", out1_valid, out1_data, out0_data);
    end
    out0_ready = 1'b1;
    tick();
    tests++;
    if (out0_valid !== 1'b0 || cnt0 !== 16'd1 || cnt1 !== 16'd1) begin
      fails++; $display("FAIL bp_drain got=%b/%0d/%0d exp=0/1/1", out0_valid, cnt0, cnt1);
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    logic [31:0] word;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word = 32'hC0DE_0000 + 32'(i);
      in_valid = 1'b1; in_sel = 1'b0; in_data = word;
      #1;
      if (in_ready === 1'b1) accepted++;
      tick();
      tests++;
      if (out0_valid !== 1'b1 || out0_data !== word) begin
        fails++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i, out0_valid, out0_data, word);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (accepted !== 8 || cnt0 !== 16'd8 || out0_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_total got=%0d/%0d/%b exp=8/8/0", accepted, cnt0, out0_valid);
    end
  endtask

  task automatic test_saturation();
    s_rst_n = 1'b0; s_in_valid = 1'b0;
    tick();
    s_rst_n = 1'b1;
    s_in_valid = 1'b1; s_in_sel = 1'b1; s_out1_ready = 1'b1; s_out0_ready = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      s_in_data = 32'h5A00_0000 + 32'(k);
      tick();
      if (k == 10 || k == 16 || k == 21) begin
        tests++;
        if (s_cnt1 !== 4'((k - 1 > 15) ? 15 : k - 1)) begin
          fails++; $display("FAIL sat_cnt1_k%0d got=%0d exp=%0d", k, s_cnt1, (k - 1 > 15) ? 15 : k - 1);
        end
      end
    end
    s_in_valid = 1'b0;
    tick(); tick();
    tests++;
    if (s_cnt1 !== 4'd15 || s_cnt0 !== 4'd0) begin
      fails++; $display("FAIL sat_final got=%0d/%0d exp=15/0", s_cnt1, s_cnt0);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_0000;
    tick();
    in_sel = 1'b1; in_data = 32'hDEAD_0001;
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out0_valid, out1_valid} !== 2'b11) begin
      fails++; $display("FAIL midrst_full got=%b exp=11", {out0_valid, out1_valid});
    end
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hBAD0_BAD0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tests++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      fails++; $display("FAIL midrst_clear got=%b exp=00", {out0_valid, out1_valid});
    end
    tick(); tick();
    tests++;
    if ({out0_valid, out1_valid} !== 2'b00 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      fails++; $display("FAIL midrst_after got=%b/%0d/%0d exp=00/0/0", {out0_valid, out1_valid}, cnt0, cnt1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_sel = 1'b0;
    s_out0_ready = 1'b0; s_out1_ready = 1'b0;
    test_reset();
    test_routing();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
